// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stalls, mispredict flushes,
// memory-wait freeze with a deferred redirect, operand forwarding and perf counters.
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs_D,
    input  logic [4:0]  Rt_D,
    input  logic [4:0]  Rs_E,
    input  logic [4:0]  Rt_E,
    input  logic [4:0]  write_reg_E,
    input  logic [4:0]  write_reg_M,
    input  logic [4:0]  write_reg_W,
    input  logic        reg_write_E,
    input  logic        reg_write_M,
    input  logic        reg_write_W,
    input  logic        mem_to_reg_E,
    input  logic        mispredict_E,
    input  logic        mem_busy_M,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        stall_M,
    output logic        flush_D,
    output logic        bubble_E,
    output logic [1:0]  forward_A_E,
    output logic [1:0]  forward_B_E,
    output logic [1:0]  state,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        StRun       = 2'b00,
        StLoadStall = 2'b01,
        StFlush     = 2'b10,
        StMemWait   = 2'b11
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic        r_pending;
    logic        w_pending_next;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic w_lu;
    logic w_stall_f;
    logic w_stall_d;
    logic w_stall_e;
    logic w_stall_m;
    logic w_flush_d;
    logic w_bubble_e;

    assign w_lu = mem_to_reg_E & reg_write_E & (write_reg_E != 5'd0) &
                  ((write_reg_E == Rs_D) | (write_reg_E == Rt_D));

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_stall_f      = 1'b0;
        w_stall_d      = 1'b0;
        w_stall_e      = 1'b0;
        w_stall_m      = 1'b0;
        w_flush_d      = 1'b0;
        w_bubble_e     = 1'b0;
        if (mem_busy_M) begin
            // Freeze dominates everything; a redirect seen now is replayed on exit.
            w_stall_f      = 1'b1;
            w_stall_d      = 1'b1;
            w_stall_e      = 1'b1;
            w_stall_m      = 1'b1;
            w_state_next   = StMemWait;
            w_pending_next = r_pending | mispredict_E;
        end else begin
            w_pending_next = 1'b0;
            case (r_state)
                StLoadStall: begin
                    w_state_next = StRun;
                end
                StFlush: begin
                    w_flush_d    = 1'b1;
                    w_bubble_e   = 1'b1;
                    w_state_next = mispredict_E ? StFlush : StRun;
                end
                default: begin
                    // RUN, and the exit cycle of MEM_WAIT, share the same decision.
                    if (mispredict_E | r_pending) begin
                        w_flush_d    = 1'b1;
                        w_bubble_e   = 1'b1;
                        w_state_next = StFlush;
                    end else if (w_lu) begin
                        w_stall_f    = 1'b1;
                        w_stall_d    = 1'b1;
                        w_bubble_e   = 1'b1;
                        w_state_next = StLoadStall;
                    end else begin
                        w_state_next = StRun;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StRun;
            r_pending   <= 1'b0;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            if (w_stall_d && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if ((w_state_next == StFlush) && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    // Control outputs are forced low for as long as reset is held.
    assign stall_F  = w_stall_f & reset;
    assign stall_D  = w_stall_d & reset;
    assign stall_E  = w_stall_e & reset;
    assign stall_M  = w_stall_m & reset;
    assign flush_D  = w_flush_d & reset;
    assign bubble_E = w_bubble_e & reset;

    assign state       = r_state;
    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

    always_comb begin
        forward_A_E = 2'b00;
        if (reg_write_M && (write_reg_M != 5'd0) && (write_reg_M == Rs_E)) begin
            forward_A_E = 2'b10;
        end else if (reg_write_W && (write_reg_W != 5'd0) && (write_reg_W == Rs_E)) begin
            forward_A_E = 2'b01;
        end
    end

    always_comb begin
        forward_B_E = 2'b00;
        if (reg_write_M && (write_reg_M != 5'd0) && (write_reg_M == Rt_E)) begin
            forward_B_E = 2'b10;
        end else if (reg_write_W && (write_reg_W != 5'd0) && (write_reg_W == Rt_E)) begin
            forward_B_E = 2'b01;
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single rising-edge clock.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 The block SHALL have the ports Rs_D and Rt_D, inputs, 5 bits each: source registers of the instruction in decode.
REQ-004 The block SHALL have the ports Rs_E and Rt_E, inputs, 5 bits each: source registers of the instruction in execute.
REQ-005 The block SHALL have the ports write_reg_E, write_reg_M and write_reg_W, inputs, 5 bits each: destination register per stage.
REQ-006 The block SHALL have the ports reg_write_E, reg_write_M, reg_write_W and mem_to_reg_E, inputs, 1 bit each: per-stage control bits.
REQ-007 The block SHALL have the port mispredict_E, input, 1 bit: branch, jump or jumpR redirect resolved in execute.
REQ-008 The block SHALL have the port mem_busy_M, input, 1 bit: data memory not ready; the whole pipeline must freeze.
REQ-009 The block SHALL have the ports stall_F, stall_D, stall_E and stall_M, outputs, 1 bit each: hold the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-010 The block SHALL have the port flush_D, output, 1 bit: clear IF/ID.
REQ-011 The block SHALL have the port bubble_E, output, 1 bit: drives the ID/EX register's zeroing stall input.
REQ-012 The block SHALL have the ports forward_A_E and forward_B_E, outputs, 2 bits each: 00 = register file, 10 = from M, 01 = from W.
REQ-013 The block SHALL have the port state, output, 2 bits: the FSM state.
REQ-014 The block SHALL have the ports stall_count and flush_count, outputs, 16 bits each: performance counters.

Function
REQ-015 The FSM SHALL have four states, encoded as follows: RUN=00, LOAD_STALL=01, FLUSH=10, MEM_WAIT=11.
REQ-016 Load-use hazard SHALL be computed as lu = mem_to_reg_E & reg_write_E & (write_reg_E!=0) & (write_reg_E==Rs_D | write_reg_E==Rt_D).
REQ-017 Event priority each cycle SHALL be: mem_busy_M > mispredict_E (or pending mispredict) > lu.
REQ-018 RUN SHALL behave as follows:
  - mem_busy_M -> MEM_WAIT.
  - else mispredict_E -> FLUSH.
  - else lu -> LOAD_STALL.
  - else remain in RUN.
REQ-019 The cycle in which lu is detected from RUN SHALL assert stall_F=stall_D=bubble_E=1 combinationally; LOAD_STALL then lasts exactly one cycle with all outputs deasserted and returns to RUN.
REQ-020 FLUSH SHALL behave as follows:
  - flush_D=bubble_E=1 combinationally in the detection cycle and for the whole single FLUSH cycle, i.e. 2 cycles total.
  - A new mispredict_E during FLUSH restarts FLUSH for one more cycle.
  - lu is ignored while in FLUSH.
REQ-021 MEM_WAIT SHALL behave as follows:
  - stall_F=stall_D=stall_E=stall_M=1 while mem_busy_M=1, including the entry cycle.
  - bubble_E=0 and flush_D=0.
  - Exit when mem_busy_M=0: to FLUSH if the pending flag is set, else to RUN.
REQ-022 A mispredict_E seen while mem_busy_M=1 SHALL set a 1-bit pending flag; the flag is cleared on entry to FLUSH.
REQ-023 Forwarding SHALL be purely combinational and evaluated independently for Rs_E and Rt_E:
  - 10 if reg_write_M & write_reg_M!=0 & write_reg_M matches.
  - else 01 if reg_write_W & write_reg_W!=0 & write_reg_W matches.
  - else 00.
REQ-024 stall_count SHALL increment by 1 on each clock edge in which stall_D=1.
REQ-025 flush_count SHALL increment by 1 on each entry into FLUSH.
REQ-026 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-027 Register 0 SHALL never cause a hazard or a forward.

Reset
REQ-028 While reset=0 the block SHALL asynchronously force: state=RUN, pending=0, stall_count=0, flush_count=0.
REQ-029 While reset=0 all stall, flush and bubble outputs SHALL be 0, regardless of inputs.
REQ-030 Reset asserted mid-FLUSH or mid-MEM_WAIT SHALL abort the sequence; the first cycle after release starts in RUN.

Verification
REQ-031 Load-use: mem_to_reg_E=1, reg_write_E=1, write_reg_E=5, Rs_D=5 -> one cycle of stall_F=stall_D=bubble_E=1, then LOAD_STALL, then RUN; stall_count=1.
REQ-032 Mispredict: mispredict_E pulsed for 1 cycle in RUN -> flush_D=bubble_E=1 for exactly 2 cycles; flush_count=1; lu present at the same time is ignored.
REQ-033 Memory freeze with pending: mem_busy_M=1 for 3 cycles with mispredict_E pulsed in the 2nd -> all four stalls high 3 cycles, then FLUSH 1 cycle, then RUN.
REQ-034 Forwarding: write_reg_M=write_reg_W=7, both reg_write=1, Rs_E=7 -> forward_A_E=10; with write_reg_M=0 -> 01; with Rs_E=0 -> 00.
REQ-035 Saturation and reset: preload via 65535 stalls -> stall_count=FFFF and holds; drive reset=0 mid-MEM_WAIT -> state=00, counters 0, all stall outputs 0 immediately.
